// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported memory, data priority with a fetch starvation guard.
// Define MEM_ARB_PERF_CNT_EN to add grant and conflict-cycle performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_dm
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_if_gnt;
    logic              r_dm_gnt;
    logic              r_if_valid;
    logic              r_dm_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_starve_hit;
    logic w_pick_if;

    assign w_starve_hit = (r_starve_cnt == LIMIT);
    // Fetch wins when it is alone, or when data has beaten it STARVE_LIMIT times in a row.
    assign w_pick_if    = if_req & (~dm_req | w_starve_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_if_gnt     <= 1'b0;
            r_dm_gnt     <= 1'b0;
            r_if_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            // NOTE: pulse outputs get a non-blocking default here; a later assignment in the same edge wins.
            r_if_gnt   <= 1'b0;
            r_dm_gnt   <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_if) begin
                        r_state      <= BUSY_IF;
                        r_if_gnt     <= 1'b1;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_starve_cnt <= '0;
                    end else if (dm_req) begin
                        r_state     <= BUSY_DM;
                        r_dm_gnt    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        if (if_req && (r_starve_cnt < LIMIT))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        r_if_rdata <= mem_rdata;
                        r_if_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                BUSY_DM: begin
                    if (mem_ready) begin
                        if (!r_mem_we)
                            r_dm_rdata <= mem_rdata;
                        r_dm_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign dm_gnt    = r_dm_gnt;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign stall_if = if_req & ~r_if_valid;
    assign stall_dm = dm_req & ~r_dm_valid;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;
    logic [31:0] r_perf_conf;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_if   <= '0;
            r_perf_dm   <= '0;
            r_perf_conf <= '0;
        end else begin
            if (r_if_gnt)
                r_perf_if <= r_perf_if + 32'd1;
            if (r_dm_gnt)
                r_perf_dm <= r_perf_dm + 32'd1;
            if (stall_if && stall_dm)
                r_perf_conf <= r_perf_conf + 32'd1;
        end
    end

    assign perf_if_grants       = r_perf_if;
    assign perf_dm_grants       = r_perf_dm;
    assign perf_conflict_cycles = r_perf_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: fetch, load, store with wait states,
// stall outputs, reset mid-access and the data/fetch starvation guard.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_dm;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]       perf_if_grants;
    logic [31:0]       perf_dm_grants;
    logic [31:0]       perf_conflict_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt),
        .dm_valid(dm_valid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if(stall_if),
        .stall_dm(stall_dm)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_grants(perf_if_grants),
        .perf_dm_grants(perf_dm_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_req, mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {if_gnt, dm_gnt, if_valid, dm_valid, mem_req, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        total++;
        if ({stall_if, stall_dm} !== 2'b00) begin
            bad++;
            $display("FAIL reset_stall got=%b want=00", {stall_if, stall_dm});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_rdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        tick();
        total++;
        if ({if_gnt, dm_gnt, mem_req, mem_we} !== 4'b1010) begin
            bad++;
            $display("FAIL fetch_gnt got=%b want=1010", {if_gnt, dm_gnt, mem_req, mem_we});
        end
        total++;
        if (mem_addr !== 32'h10) begin
            bad++;
            $display("FAIL fetch_addr got=%h want=00000010", mem_addr);
        end
        tick();
        total++;
        if ({if_valid, if_gnt, mem_req} !== 3'b100) begin
            bad++;
            $display("FAIL fetch_valid got=%b want=100", {if_valid, if_gnt, mem_req});
        end
        total++;
        if (if_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL fetch_rdata got=%h want=deadbeef", if_rdata);
        end
        if_req = 1'b0;
        tick();
        total++;
        if ({if_valid, mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_pulse got=%b want=00", {if_valid, mem_req});
        end
    endtask

    task automatic test_load();
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h20;
        mem_rdata = 32'hCAFE_F00D;
        mem_ready = 1'b1;
        tick();
        total++;
        if ({dm_gnt, if_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h20) begin
            bad++;
            $display("FAIL load_gnt got=%b/%h want=1010/00000020", {dm_gnt, if_gnt, mem_req, mem_we}, mem_addr);
        end
        tick();
        total++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL load_data got=%b/%h want=1/cafef00d", dm_valid, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        dm_addr   = 32'h40;
        dm_wdata  = 32'h1234;
        mem_rdata = 32'h5555_5555;
        mem_ready = 1'b0;
        tick();
        total++;
        if ({dm_gnt, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
            bad++;
            $display("FAIL store_gnt got=%b/%h/%h want=11/00000040/00001234", {dm_gnt, mem_we}, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_req !== 1'b1 || dm_valid !== 1'b0) begin
                bad++;
                $display("FAIL store_busy%0d got=%b want=10", i, {mem_req, dm_valid});
            end
            mem_ready = (i == 3);
            tick();
        end
        total++;
        if ({dm_valid, mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL store_valid got=%b want=10", {dm_valid, mem_req});
        end
        total++;
        if (dm_rdata !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL store_rdata got=%h want=cafef00d", dm_rdata);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        mem_ready = 1'b0;
        if_addr   = 32'h80;
        total++;
        if (stall_if !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle got=%b want=0", stall_if);
        end
        if_req = 1'b1;
        #1;
        total++;
        if (stall_if !== 1'b1) begin
            bad++;
            $display("FAIL stall_rise got=%b want=1", stall_if);
        end
        tick();
        tick();
        total++;
        if ({stall_if, stall_dm, mem_req} !== 3'b101) begin
            bad++;
            $display("FAIL stall_busy got=%b want=101", {stall_if, stall_dm, mem_req});
        end
        mem_ready = 1'b1;
        tick();
        total++;
        if ({if_valid, stall_if} !== 2'b10) begin
            bad++;
            $display("FAIL stall_valid got=%b want=10", {if_valid, stall_if});
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h60;
        mem_ready = 1'b0;
        tick();
        total++;
        if ({dm_gnt, mem_req} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_gnt got=%b want=11", {dm_gnt, mem_req});
        end
        if_req  = 1'b1;
        if_addr = 32'h90;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({mem_req, dm_valid, dm_gnt, if_gnt} !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_abort got=%b want=0000", {mem_req, dm_valid, dm_gnt, if_gnt});
        end
        reset  = 1'b0;
        dm_req = 1'b0;
        mem_ready = 1'b1;
        tick();
        total++;
        if ({if_gnt, dm_valid, mem_req} !== 3'b101 || mem_addr !== 32'h90) begin
            bad++;
            $display("FAIL rstmid_regrant got=%b/%h want=101/00000090", {if_gnt, dm_valid, mem_req}, mem_addr);
        end
        tick();
        total++;
        if ({if_valid, dm_valid} !== 2'b10) begin
            bad++;
            $display("FAIL rstmid_valid got=%b want=10", {if_valid, dm_valid});
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        logic [9:0] exp_if;
        int         ngr;
        int         conf;
        exp_if = 10'b10_0001_0000;
        ngr    = 0;
        conf   = 0;
        reset  = 1'b1;
        tick();
        reset     = 1'b0;
        tick();
        if_req    = 1'b1;
        if_addr   = 32'h100;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h200;
        mem_rdata = 32'hA5A5_0001;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && ngr < 10; cyc++) begin
            #1;
            if (stall_if && stall_dm)
                conf++;
            tick();
            if (if_gnt || dm_gnt) begin
                total++;
                if ((if_gnt && dm_gnt) || if_gnt !== exp_if[ngr]) begin
                    bad++;
                    $display("FAIL conflict_grant%0d got if=%b dm=%b want if=%b", ngr, if_gnt, dm_gnt, exp_if[ngr]);
                end
                ngr++;
                if (ngr == 10)
                    dm_req = 1'b0;
            end
        end
        total++;
        if (ngr != 10) begin
            bad++;
            $display("FAIL conflict_timeout got=%0d grants want=10", ngr);
        end
        #1;
        if (stall_if && stall_dm)
            conf++;
        tick();
        total++;
        if ({if_valid, dm_valid} !== 2'b10 || if_rdata !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL conflict_last got=%b/%h want=10/a5a50001", {if_valid, dm_valid}, if_rdata);
        end
        if_req = 1'b0;
        tick();
        total++;
        if (conf != 10) begin
            bad++;
            $display("FAIL conflict_cycles got=%0d want=10", conf);
        end
`ifdef MEM_ARB_PERF_CNT_EN
        total++;
        if (perf_if_grants !== 32'd2 || perf_dm_grants !== 32'd8) begin
            bad++;
            $display("FAIL perf_grants got=%0d/%0d want=2/8", perf_if_grants, perf_dm_grants);
        end
        total++;
        if (perf_conflict_cycles !== 32'(conf) || perf_conflict_cycles == 32'd0) begin
            bad++;
            $display("FAIL perf_conflict got=%0d want=%0d", perf_conflict_cycles, conf);
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_stall();
        test_reset_mid();
        test_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters:
  - the instruction-fetch path (fetch unit / instruction memory read);
  - the data path (memory-stage load/store).
- Sequences each access through a small FSM and returns registered read data with a one-cycle valid pulse.
- Drives per-requester stall outputs to the pipeline hazard logic.
- Data accesses have priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants won against a waiting fetch before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse when the fetch access is issued.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  registered fetch read data.
- dm_req  in  1  data request; held until dm_valid.
- dm_we  in  1  1 = store, 0 = load; stable while dm_req is high.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  one-cycle pulse when the data access is issued.
- dm_valid  out  1  one-cycle pulse; load data valid or store complete.
- dm_rdata  out  DATA_W  registered load data.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- stall_if  out  1  fetch stall = if_req & ~if_valid (combinational).
- stall_dm  out  1  data stall = dm_req & ~dm_valid (combinational).

Behaviour:
- **Reset values:** state IDLE. All outputs 0, including rdata registers, starve_cnt and the mem_* registers.
- **FSM states:** IDLE, BUSY_IF, BUSY_DM.
- **IDLE, on each clock edge:**
  - Only dm_req → BUSY_DM.
  - Only if_req → BUSY_IF.
  - Both requests → BUSY_DM, unless starve_cnt == STARVE_LIMIT, in which case → BUSY_IF.
  - On entry, the address, we and wdata of the winner are latched into mem_addr, mem_we and mem_wdata. mem_we is 0 for fetch.
- **Grant:** x_gnt is high for exactly the first cycle of BUSY_x.
- **BUSY_x:**
  - mem_req = 1 for the whole state.
  - On an edge where mem_ready = 1:
    - fetch: mem_rdata is captured into if_rdata.
    - data load: mem_rdata is captured into dm_rdata.
    - data store: dm_rdata is left unchanged.
    - x_valid = 1 the next cycle, and state → IDLE.
  - mem_req drops in that IDLE cycle.
- **Latency:**
  - Request at cycle t → gnt and mem_req at t+1.
  - With mem_ready at t+1 → valid at t+2.
  - Back-to-back accesses have one IDLE cycle between them; the next grant is earliest at t+3.
- **starve_cnt (4 bits):**
  - +1 when data is granted while if_req = 1; saturates at STARVE_LIMIT.
  - Cleared on any fetch grant.
  - Unchanged otherwise.
- **mem_ready outside BUSY:** ignored.
- **Request dropped mid-access (protocol violation):** the access still completes and valid still pulses.
- **Simultaneous valid and new request from the same requester:** the new request is arbitrated in the IDLE cycle that follows.
- **Reset mid-access:** the transaction is abandoned. The next cycle has mem_req = 0 and state IDLE, and no valid pulse is issued.
- **Concurrency:** only one requester is ever active. if_gnt and dm_gnt are never high together, nor are if_valid and dm_valid.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- **When defined:** adds three 32-bit outputs, each reset to 0 and wrapping on overflow:
  - perf_if_grants: +1 per if_gnt.
  - perf_dm_grants: +1 per dm_gnt.
  - perf_conflict_cycles: +1 for each cycle with stall_if & stall_dm.
- **When undefined:** these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- **Fetch only, mem_ready tied 1:** if_req at cycle 1 with if_addr = 0x10 and mem_rdata = 0xDEADBEEF → if_gnt at cycle 2 with mem_addr = 0x10 and mem_we = 0; if_valid at cycle 3 with if_rdata = 0xDEADBEEF.
- **Store with wait states:** dm_req, dm_we = 1, dm_addr = 0x40, dm_wdata = 0x1234, mem_ready low for 3 BUSY cycles → mem_req high for 4 cycles with mem_wdata = 0x1234; dm_valid 1 cycle later; dm_rdata unchanged.
- **Conflict:** if_req and dm_req both high continuously, STARVE_LIMIT = 4, mem_ready = 1 → grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF.
- **Reset during BUSY_DM (mem_ready = 0), then reset released:** mem_req = 0 the next cycle, no dm_valid, state IDLE; a pending if_req is then granted normally.
- **Stall outputs:** stall_if is high from the if_req rising edge until the if_valid cycle and low in the if_valid cycle.
- **With MEM_ARB_PERF_CNT_EN, after the conflict test:** perf_if_grants = 2, perf_dm_grants = 8, perf_conflict_cycles > 0 and matches the count of cycles where both stalls were high.
